// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV32I opcodes, ALU/immediate encodings and the decoded control bundle.
package rv_decode_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR = 4'h3,
    ALU_XOR = 4'h4, ALU_SLL = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7,
    ALU_SLT = 4'h8, ALU_SLTU = 4'h9, ALU_PASS_B = 4'hA, ALU_INVALID = 4'hF
  } alu_op_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef struct packed {
    alu_op_e alu;
    logic    alu_src;
    logic    pc_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } decode_ctrl_t;
  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: builds the sign-extended I/S/B/U/J immediate from an instruction word.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  imm_type_e       i_imm_type,
  output logic [XLEN-1:0] o_imm
);
  logic [31:0] w_imm;
  always_comb begin
    case (i_imm_type)
      IMM_I:   w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   w_imm = {i_instr[31:12], 12'b0};
      IMM_J:   w_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end
  assign o_imm = XLEN'($signed(w_imm));
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decoder with valid/ready handshake and flush.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PC_W       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_W-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [XLEN-1:0]       out_imm,
  output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
  output logic [2:0]            out_funct3,
  output logic                  out_alu_src,
  output logic                  out_pc_src,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic                  out_illegal
);
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_accept;
  decode_ctrl_t    w_ctrl;
  imm_type_e       w_imm_type;
  logic [XLEN-1:0] w_imm;
  logic            r_valid;
  decode_ctrl_t    r_ctrl;
  logic [XLEN-1:0] r_imm;
  logic [24:7]     r_fields;
  logic [PC_W-1:0] r_pc;
  assign w_op     = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // Start from the illegal bundle; each recognised encoding overrides it.
  always_comb begin
    w_ctrl         = '0;
    w_ctrl.alu     = ALU_INVALID;
    w_ctrl.illegal = 1'b1;
    w_imm_type     = IMM_NONE;
    case (w_op)
      OPC_OP: if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
        w_ctrl.alu       = f3_alu(w_f3, w_f7[5]);
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
      end
      OPC_OP_IMM: if (w_f3 != 3'b001 || w_f7 == 7'h00) begin
        w_ctrl.alu       = f3_alu(w_f3, w_f3 == 3'b101 && in_instr[30]);
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_I;
      end
      OPC_LOAD: if (w_f3 != 3'b011 && w_f3[2:1] != 2'b11) begin
        w_ctrl.alu       = ALU_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_I;
      end
      OPC_STORE: if (w_f3[2] == 1'b0 && w_f3 != 3'b011) begin
        w_ctrl.alu       = ALU_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_S;
      end
      OPC_BRANCH: if (w_f3[2:1] != 2'b01) begin
        w_ctrl.alu     = ALU_SUB;
        w_ctrl.branch  = 1'b1;
        w_ctrl.illegal = 1'b0;
        w_imm_type     = IMM_B;
      end
      OPC_JAL: begin
        w_ctrl.alu       = ALU_ADD;
        w_ctrl.jump      = 1'b1;
        w_ctrl.pc_src    = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_J;
      end
      OPC_JALR: if (w_f3 == 3'b000) begin
        w_ctrl.alu       = ALU_ADD;
        w_ctrl.jump      = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_I;
      end
      OPC_LUI: begin
        w_ctrl.alu       = ALU_PASS_B;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_U;
      end
      OPC_AUIPC: begin
        w_ctrl.alu       = ALU_ADD;
        w_ctrl.pc_src    = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.illegal   = 1'b0;
        w_imm_type       = IMM_U;
      end
      default: ;
    endcase
    if (in_instr[11:7] == 5'd0) w_ctrl.reg_write = 1'b0;
  end
  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr   (in_instr[31:7]),
    .i_imm_type(w_imm_type),
    .o_imm     (w_imm)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_imm    <= '0;
      r_fields <= '0;
      r_pc     <= '0;
    end else begin
      r_valid <= !flush && (w_accept || (r_valid && !out_ready));
      if (w_accept && !flush) begin
        r_ctrl   <= w_ctrl;
        r_imm    <= w_imm;
        r_fields <= in_instr[24:7];
        r_pc     <= in_pc;
      end
    end
  end
  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rd        = r_fields[11:7];
  assign out_funct3    = r_fields[14:12];
  assign out_rs1       = r_fields[19:15];
  assign out_rs2       = r_fields[24:20];
  assign out_imm       = r_imm;
  assign out_alu_ctrl  = ALU_CTRL_W'(r_ctrl.alu);
  assign out_alu_src   = r_ctrl.alu_src;
  assign out_pc_src    = r_ctrl.pc_src;
  assign out_reg_write = r_ctrl.reg_write;
  assign out_mem_read  = r_ctrl.mem_read;
  assign out_mem_write = r_ctrl.mem_write;
  assign out_branch    = r_ctrl.branch;
  assign out_jump      = r_ctrl.jump;
  assign out_illegal   = r_ctrl.illegal;
endmodule
